// File: rtl/i2c_sender_pkg.sv
// i2c_sender_pkg
//   Shared definitions for the SB_I2C init-time register writer:
//   SB_I2C register offsets (sbadr[3:0]), CMDR command bytes, the bus FSM
//   state encoding and the write ROM (rom_entry).
//   Optional feature macro used by the design: I2C_SENDER_STATUS_POLL_EN.
package i2c_sender_pkg;

    // SB_I2C register offsets, low nibble of sbadr
    localparam logic [3:0] REG_CR1   = 4'h8;
    localparam logic [3:0] REG_CMDR  = 4'h9;
    localparam logic [3:0] REG_BRLSB = 4'hA;
    localparam logic [3:0] REG_BRMSB = 4'hB;
    localparam logic [3:0] REG_SR    = 4'hC;
    localparam logic [3:0] REG_TXDR  = 4'hD;

    localparam logic [7:0] CR1_EN     = 8'h80;
    localparam logic [7:0] CMD_STA_WR = 8'h94;  // STA | WR | CKSDIS
    localparam logic [7:0] CMD_WR     = 8'h14;  // WR | CKSDIS
    localparam logic [7:0] CMD_STO    = 8'h44;  // STO | CKSDIS

    localparam int SR_TRRDY_BIT = 2;

    typedef enum logic [1:0] {
        BUS_IDLE     = 2'd0,
        BUS_SETUP    = 2'd1,
        BUS_WAIT_ACK = 2'd2,
        BUS_DONE     = 2'd3
    } bus_state_e;

    typedef struct packed {
        logic [6:0] slave;
        logic [7:0] rgst;
        logic [7:0] data;
    } rom_entry_t;

    // Register writes played after the IP is configured.
    function automatic rom_entry_t rom_entry(input logic [7:0] k);
        rom_entry_t e;
        case (k)
            8'd0:    e = '{slave: 7'h3C, rgst: 8'h12, data: 8'h80};
            8'd1:    e = '{slave: 7'h3C, rgst: 8'h11, data: 8'h01};
            8'd2:    e = '{slave: 7'h3C, rgst: 8'h0C, data: 8'h04};
            8'd3:    e = '{slave: 7'h3C, rgst: 8'h3A, data: 8'h0D};
            default: e = '{slave: 7'h3C, rgst: 8'h00, data: 8'h00};
        endcase
        return e;
    endfunction

endpackage

// File: rtl/i2c_reg_sender_sb_bus_ctrl.sv
// sb_bus_ctrl
//   Single-transaction System Bus master for the SB_I2C hard IP.
//   IDLE -> SETUP -> WAIT_ACK (until sback) -> DONE (done pulse) -> IDLE.
//   No timeout: a missing sback stalls in WAIT_ACK with outputs held.
// Ports
//   clock, reset           : clock, asynchronous active-high reset
//   req, req_rw, req_adr,
//   req_dat                : request, accepted only in IDLE
//   sback, sbdat_in        : SB acknowledge and read data from the IP
//   sbstb, sbrw, sbadr,
//   sbdat_out              : SB master outputs (registered)
//   rd_data                : read data captured on acknowledge
//   done                   : one-cycle pulse while in DONE
module sb_bus_ctrl
    import i2c_sender_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       req,
    input  logic       req_rw,
    input  logic [7:0] req_adr,
    input  logic [7:0] req_dat,
    input  logic       sback,
    input  logic [7:0] sbdat_in,
    output logic       sbstb,
    output logic       sbrw,
    output logic [7:0] sbadr,
    output logic [7:0] sbdat_out,
    output logic [7:0] rd_data,
    output logic       done
);

    bus_state_e state, state_d;
    logic       sbstb_q, sbstb_d;
    logic       sbrw_q, sbrw_d;
    logic [7:0] sbadr_q, sbadr_d;
    logic [7:0] sbdat_q, sbdat_d;
    logic [7:0] rd_q, rd_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= BUS_IDLE;
            sbstb_q <= 1'b0;
            sbrw_q  <= 1'b0;
            sbadr_q <= 8'h00;
            sbdat_q <= 8'h00;
            rd_q    <= 8'h00;
        end else begin
            state   <= state_d;
            sbstb_q <= sbstb_d;
            sbrw_q  <= sbrw_d;
            sbadr_q <= sbadr_d;
            sbdat_q <= sbdat_d;
            rd_q    <= rd_d;
        end
    end

    // The strobe register is set on entry to SETUP and cleared on entry to
    // DONE, so it is high for exactly SETUP and WAIT_ACK.
    always_comb begin
        state_d = state;
        sbstb_d = sbstb_q;
        sbrw_d  = sbrw_q;
        sbadr_d = sbadr_q;
        sbdat_d = sbdat_q;
        rd_d    = rd_q;
        case (state)
            BUS_IDLE: begin
                if (req) begin
                    sbadr_d = req_adr;
                    sbdat_d = req_dat;
                    sbrw_d  = req_rw;
                    sbstb_d = 1'b1;
                    state_d = BUS_SETUP;
                end
            end
            BUS_SETUP: state_d = BUS_WAIT_ACK;
            BUS_WAIT_ACK: begin
                if (sback) begin
                    rd_d    = sbdat_in;
                    sbstb_d = 1'b0;
                    state_d = BUS_DONE;
                end
            end
            BUS_DONE: state_d = BUS_IDLE;
            default:  state_d = BUS_IDLE;
        endcase
    end

    assign sbstb     = sbstb_q;
    assign sbrw      = sbrw_q;
    assign sbadr     = sbadr_q;
    assign sbdat_out = sbdat_q;
    assign rd_data   = rd_q;
    assign done      = (state == BUS_DONE);

endmodule

// File: rtl/i2c_reg_sender.sv
// i2c_reg_sender
//   Init-time I2C register writer for the iCE40UP SB_I2C hard IP. Enables the
//   IP, sets the SCL prescale, then turns every ROM entry into one I2C write
//   (START+addr/W, reg, data, STOP) and idles forever once done.
//   Macro I2C_SENDER_STATUS_POLL_EN: byte waits poll I2CSR.TRRDY over SB reads;
//   otherwise each byte wait is a fixed WAIT_CYCLES idle period (writes only).
// Ports
//   clock, reset          : system clock, asynchronous active-high reset
//   sbdat_from_peripheral : SB read data      sback : SB acknowledge
//   i2c_irq, i2c_wkup     : unused IP outputs
//   sbclk                 : SB clock (= clock)
//   sbrw, sbstb, sbadr,
//   sbdat_to_peripheral   : SB master outputs
module i2c_reg_sender
    import i2c_sender_pkg::*;
#(
    parameter logic [3:0] SB_IP_SEL   = 4'h1,
    parameter logic [9:0] PRESCALE    = 10'd5,
    parameter int         NUM_WRITES  = 4,
    parameter int         WAIT_CYCLES = 200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] sbdat_from_peripheral,
    input  logic       sback,
    input  logic       i2c_irq,
    input  logic       i2c_wkup,
    output logic       sbclk,
    output logic       sbrw,
    output logic       sbstb,
    output logic [7:0] sbadr,
    output logic [7:0] sbdat_to_peripheral
);

    typedef enum logic [1:0] {SQ_ISSUE, SQ_BUSY, SQ_DELAY, SQ_FIN} seq_state_e;

    localparam logic [7:0]  LAST_ENTRY = 8'(NUM_WRITES - 1);
    localparam logic [15:0] WAIT_LAST  = 16'(WAIT_CYCLES - 1);
    localparam logic [3:0]  LAST_STEP  = 4'd12;
    localparam logic [3:0]  FIRST_ENTRY_STEP = 4'd3;

    seq_state_e seq_q, seq_d;
    logic [3:0]  step_q, step_d;    // 0..2 IP config, 3..12 one ROM entry
    logic [7:0]  entry_q, entry_d;
    logic [15:0] cnt_q, cnt_d;

    logic       req, req_rw, done, advance;
    logic [7:0] req_adr, req_dat, rd_data;
    logic       step_wait;
    logic [3:0] step_reg;
    logic [7:0] step_dat;
    rom_entry_t ent;

    assign ent   = rom_entry(entry_q);
    assign sbclk = clock;

    // Micro-program: register/data for each step, or a byte wait.
    always_comb begin
        step_wait = 1'b0;
        step_reg  = REG_CMDR;
        step_dat  = CMD_STO;
        case (step_q)
            4'd0:  begin step_reg = REG_CR1;   step_dat = CR1_EN;                  end
            4'd1:  begin step_reg = REG_BRLSB; step_dat = PRESCALE[7:0];           end
            4'd2:  begin step_reg = REG_BRMSB; step_dat = {6'b0, PRESCALE[9:8]};   end
            4'd3:  begin step_reg = REG_TXDR;  step_dat = {ent.slave, 1'b0};       end
            4'd4:  begin step_reg = REG_CMDR;  step_dat = CMD_STA_WR;              end
            4'd6:  begin step_reg = REG_TXDR;  step_dat = ent.rgst;                end
            4'd7:  begin step_reg = REG_CMDR;  step_dat = CMD_WR;                  end
            4'd9:  begin step_reg = REG_TXDR;  step_dat = ent.data;                end
            4'd10: begin step_reg = REG_CMDR;  step_dat = CMD_WR;                  end
            4'd5, 4'd8, 4'd11: begin
                step_wait = 1'b1;
                step_reg  = REG_SR;
                step_dat  = 8'h00;
            end
            default: begin step_reg = REG_CMDR; step_dat = CMD_STO; end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seq_q   <= SQ_ISSUE;
            step_q  <= 4'd0;
            entry_q <= 8'd0;
            cnt_q   <= 16'd0;
        end else begin
            seq_q   <= seq_d;
            step_q  <= step_d;
            entry_q <= entry_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        seq_d   = seq_q;
        step_d  = step_q;
        entry_d = entry_q;
        cnt_d   = cnt_q;
        req     = 1'b0;
        req_rw  = 1'b1;
        req_adr = {SB_IP_SEL, step_reg};
        req_dat = step_dat;
        advance = 1'b0;
        case (seq_q)
            SQ_ISSUE: begin
                if (step_wait) begin
`ifdef I2C_SENDER_STATUS_POLL_EN
                    req    = 1'b1;
                    req_rw = 1'b0;
                    seq_d  = SQ_BUSY;
`else
                    cnt_d  = 16'd0;
                    seq_d  = SQ_DELAY;
`endif
                end else begin
                    req   = 1'b1;
                    seq_d = SQ_BUSY;
                end
            end
            SQ_BUSY: begin
                if (done) begin
`ifdef I2C_SENDER_STATUS_POLL_EN
                    // Status read without TRRDY: read I2CSR again.
                    if (step_wait && !rd_data[SR_TRRDY_BIT]) seq_d = SQ_ISSUE;
                    else                                      advance = 1'b1;
`else
                    advance = 1'b1;
`endif
                end
            end
            SQ_DELAY: begin
                if (cnt_q == WAIT_LAST) advance = 1'b1;
                else                    cnt_d = cnt_q + 16'd1;
            end
            default: ;
        endcase

        if (advance) begin
            if (step_q == LAST_STEP) begin
                if (entry_q == LAST_ENTRY) begin
                    seq_d = SQ_FIN;
                end else begin
                    entry_d = entry_q + 8'd1;
                    step_d  = FIRST_ENTRY_STEP;
                    seq_d   = SQ_ISSUE;
                end
            end else begin
                step_d = step_q + 4'd1;
                seq_d  = SQ_ISSUE;
            end
        end
    end

    sb_bus_ctrl sbc (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .req_rw    (req_rw),
        .req_adr   (req_adr),
        .req_dat   (req_dat),
        .sback     (sback),
        .sbdat_in  (sbdat_from_peripheral),
        .sbstb     (sbstb),
        .sbrw      (sbrw),
        .sbadr     (sbadr),
        .sbdat_out (sbdat_to_peripheral),
        .rd_data   (rd_data),
        .done      (done)
    );

    // IP interrupt/wakeup are intentionally ignored; read data only matters
    // when status polling is built in.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, i2c_irq, i2c_wkup, rd_data};

endmodule

// File: tb/tb_i2c_reg_sender.sv
`timescale 1ns/1ps
module tb_i2c_reg_sender;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // main instance: default parameters
    logic       rst, sback;
    logic [7:0] rdata;
    logic       sbclk, sbrw, sbstb;
    logic [7:0] sbadr, sbdat;

    // second instance: a single ROM entry, short byte wait
    logic       rst1, sback1;
    logic [7:0] rdata1;
    logic       sbclk1, sbrw1, sbstb1;
    logic [7:0] sbadr1, sbdat1;

    int n_vec = 0;
    int n_err = 0;
    bit d1_done = 1'b0;

    i2c_reg_sender dut (
        .clock                 (clock),
        .reset                 (rst),
        .sbdat_from_peripheral (rdata),
        .sback                 (sback),
        .i2c_irq               (1'b0),
        .i2c_wkup              (1'b0),
        .sbclk                 (sbclk),
        .sbrw                  (sbrw),
        .sbstb                 (sbstb),
        .sbadr                 (sbadr),
        .sbdat_to_peripheral   (sbdat)
    );

    i2c_reg_sender #(.NUM_WRITES(1), .WAIT_CYCLES(4)) dut1 (
        .clock                 (clock),
        .reset                 (rst1),
        .sbdat_from_peripheral (rdata1),
        .sback                 (sback1),
        .i2c_irq               (1'b0),
        .i2c_wkup              (1'b0),
        .sbclk                 (sbclk1),
        .sbrw                  (sbrw1),
        .sbstb                 (sbstb1),
        .sbadr                 (sbadr1),
        .sbdat_to_peripheral   (sbdat1)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Strobe must stay high for the whole WAIT_ACK phase; without polling
    // every transaction is a write.
    always @(negedge clock) begin
        if (rst === 1'b0 && dut.sbc.state == 2'd2) begin
            check_val("stb_in_wait", {31'b0, sbstb}, 32'd1);
`ifndef I2C_SENDER_STATUS_POLL_EN
            check_val("rw_always_wr", {31'b0, sbrw}, 32'd1);
`endif
        end
    end

    task automatic wait_wack(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clock);
            if (dut.sbc.state == 2'd2) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_val("wack_timeout", 32'd0, 32'd1);
    endtask

    // Wait for WAIT_ACK, optionally stall, acknowledge with rd, check {rw,adr[,dat]}.
    task automatic exp_txn(input string tag, input logic e_rw, input logic [7:0] e_adr,
                           input logic [7:0] e_dat, input logic [7:0] rd, input bit chk_dat);
        bit ok;
        logic [7:0] d;
        wait_wack(ok);
        @(negedge clock);
        d = chk_dat ? sbdat : e_dat;
        check_val(tag, {15'b0, sbrw, sbadr, d}, {15'b0, e_rw, e_adr, e_dat});
        rdata = rd;
        sback = 1'b1;
        @(negedge clock);
        sback = 1'b0;
    endtask

    initial begin
        bit ok;
        rst   = 1'b1;
        sback = 1'b0;
        rdata = 8'h00;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_val("rst_stb",   {31'b0, sbstb}, 32'd0);
        check_val("rst_rw",    {31'b0, sbrw},  32'd0);
        check_val("rst_adr",   {24'b0, sbadr}, 32'h00);
        check_val("rst_dat",   {24'b0, sbdat}, 32'h00);
        check_val("rst_state", {30'b0, dut.sbc.state}, 32'd0);
        rst = 1'b0;

        // First write, with sback held off for a long stall.
        wait_wack(ok);
        repeat (20) @(negedge clock);
        check_val("hold_state", {30'b0, dut.sbc.state}, 32'd2);
        check_val("hold_wr", {15'b0, sbrw, sbadr, sbdat}, {15'b0, 1'b1, 8'h18, 8'h80});
        check_val("hold_stb", {31'b0, sbstb}, 32'd1);
        sback = 1'b1;
        @(negedge clock);
        sback = 1'b0;
        check_val("done_state", {30'b0, dut.sbc.state}, 32'd3);
        check_val("done_stb",   {31'b0, sbstb}, 32'd0);
        @(negedge clock);
        check_val("idle_state", {30'b0, dut.sbc.state}, 32'd0);

        exp_txn("wr_brlsb", 1'b1, 8'h1A, 8'h05, 8'h00, 1'b1);
        exp_txn("wr_brmsb", 1'b1, 8'h1B, 8'h00, 8'h00, 1'b1);
        exp_txn("wr_txdr0", 1'b1, 8'h1D, 8'h78, 8'h00, 1'b1);
        exp_txn("wr_sta",   1'b1, 8'h19, 8'h94, 8'h00, 1'b1);
`ifdef I2C_SENDER_STATUS_POLL_EN
        exp_txn("rd_sr_a",  1'b0, 8'h1C, 8'h00, 8'h00, 1'b0);
        exp_txn("rd_sr_b",  1'b0, 8'h1C, 8'h00, 8'h04, 1'b0);
`endif
        exp_txn("wr_reg",   1'b1, 8'h1D, 8'h12, 8'h04, 1'b1);

        // Reset while the CMDR write is waiting for its acknowledge.
        wait_wack(ok);
        repeat (3) @(negedge clock);
        check_val("pre_rst_wr", {16'b0, sbadr, sbdat}, 32'h1914);
        rst = 1'b1;
        #1;
        check_val("arst_stb",   {31'b0, sbstb}, 32'd0);
        check_val("arst_rw",    {31'b0, sbrw},  32'd0);
        check_val("arst_adr",   {24'b0, sbadr}, 32'h00);
        check_val("arst_dat",   {24'b0, sbdat}, 32'h00);
        check_val("arst_state", {30'b0, dut.sbc.state}, 32'd0);
        repeat (2) @(negedge clock);
        rst = 1'b0;
        exp_txn("restart", 1'b1, 8'h18, 8'h80, 8'h00, 1'b1);

        for (int i = 0; i < 3000 && !d1_done; i++) @(negedge clock);
        if (!d1_done) check_val("d1_timeout", 32'd0, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Single-entry instance: auto-acknowledge everything, reads report TRRDY.
    initial begin
        int wcount;
        int last_stb;
        logic [15:0] last_wr;
        wcount  = 0;
        last_stb = 0;
        last_wr = 16'h0000;
        rst1   = 1'b1;
        sback1 = 1'b0;
        rdata1 = 8'h04;
        repeat (2) @(negedge clock);
        rst1 = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clock);
            if (sback1) begin
                sback1 = 1'b0;
            end else if (dut1.sbc.state == 2'd2) begin
                if (sbrw1) begin
                    wcount++;
                    last_wr = {sbadr1, sbdat1};
                end
                sback1 = 1'b1;
            end
            if (sbstb1) last_stb = c;
        end
        check_val("n1_writes",   wcount, 32'd10);
        check_val("n1_last_wr",  {16'b0, last_wr}, 32'h1944);
        check_val("n1_quiet",    {31'b0, (last_stb < 400)}, 32'd1);
        check_val("n1_stb_idle", {31'b0, sbstb1}, 32'd0);
        d1_done = 1'b1;
    end

endmodule
